// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: E-stage multiply/divide unit bus
//   Start  pipeline -> unit  MD instruction valid in E stage
//   MDOp   pipeline -> unit  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo
//   A, B   pipeline -> unit  forwarded rs / rt operands
//   Busy   unit -> pipeline  long operation in flight
//   HI, LO unit -> pipeline  architectural HI/LO registers
interface mult_div_unit_if;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    modport master(output Start, MDOp, A, B, input Busy, HI, LO);
    modport slave(input Start, MDOp, A, B, output Busy, HI, LO);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: multiply/divide unit with HI/LO and fixed MIPS latencies
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of mult_div_unit_if (Start/MDOp/A/B in, Busy/HI/LO out)
module mult_div_unit #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input logic             clk,
    input logic             rst_n,
    mult_div_unit_if.slave  bus
);
    localparam int CW = $clog2(DIV_CYC + 1);
    typedef enum logic {IDLE, RUN} state_t;
    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [31:0]   r_ph, r_pl, r_hi, r_lo, w_ph, w_pl, w_hi, w_lo;
    logic [63:0]   w_prod_s, w_prod_u, w_res;
    logic [31:0]   w_abs_a, w_abs_b, w_mq, w_mr, w_sq, w_sr, w_uq, w_ur;
    assign w_prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
    assign w_prod_u = {32'b0, bus.A} * {32'b0, bus.B};
    // Signed divide on magnitudes: avoids the INT_MIN/-1 overflow case, which
    // falls out naturally as 0x80000000 rem 0.
    assign w_abs_a  = bus.A[31] ? -bus.A : bus.A;
    assign w_abs_b  = bus.B[31] ? -bus.B : bus.B;
    assign w_mq     = w_abs_a / w_abs_b;
    assign w_mr     = w_abs_a % w_abs_b;
    assign w_sq     = (bus.A[31] ^ bus.B[31]) ? -w_mq : w_mq;
    assign w_sr     = bus.A[31] ? -w_mr : w_mr;
    assign w_uq     = bus.A / bus.B;
    assign w_ur     = bus.A % bus.B;
    // Divide by zero commits the current HI/LO, i.e. leaves them unchanged.
    assign w_res    = bus.MDOp == 3'd0 ? w_prod_s :
                      bus.MDOp == 3'd1 ? w_prod_u :
                      bus.B == 32'd0   ? {r_hi, r_lo} :
                      bus.MDOp == 3'd2 ? {w_sr, w_sq} : {w_ur, w_uq};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ph    <= '0;
            r_pl    <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt;
            r_ph    <= w_ph;
            r_pl    <= w_pl;
            r_hi    <= w_hi;
            r_lo    <= w_lo;
        end
    end
    always_comb begin
        w_next = r_state;
        w_cnt  = r_cnt;
        w_ph   = r_ph;
        w_pl   = r_pl;
        w_hi   = r_hi;
        w_lo   = r_lo;
        if (r_state == IDLE) begin
            if (bus.Start && !bus.MDOp[2] && !bus.MDOp[2]) begin
                {w_ph, w_pl} = w_res;
                w_cnt        = bus.MDOp[1] ? CW'(DIV_CYC) : CW'(MULT_CYC);
                w_next       = RUN;
            end else if (bus.Start && bus.MDOp == 3'd4) w_hi = bus.A;
            else if (bus.Start && bus.MDOp == 3'd5) w_lo = bus.A;
        end else if (r_cnt == CW'(1)) begin
            w_hi   = r_ph;
            w_lo   = r_pl;
            w_cnt  = '0;
            w_next = IDLE;
        end else w_cnt = r_cnt - CW'(1);
    end
    assign bus.Busy = (r_state == RUN);
    assign bus.HI   = r_hi;
    assign bus.LO   = r_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: random + directed check of mult_div_unit against a cycle-count model
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic rst_n;
    int checks = 0;
    int errors = 0;
    mult_div_unit_if bus();
    mult_div_unit #(.MULT_CYC(5), .DIV_CYC(10)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of an MD op given the current HI/LO.
    function automatic logic [63:0] calc(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] hilo);
        longint sa, sb, q, r;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 3'd0) begin
            q = sa * sb;
            return q;
        end
        if (op == 3'd1) begin
            u = {32'b0, a} * {32'b0, b};
            return u;
        end
        if (b == 32'd0) return hilo;
        if (op == 3'd2) begin
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    // Model: an accepted long op at edge k commits at edge k+latency; busy in between.
    int          cyc, done_at;
    bit          m_run;
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_pend;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0; m_run = 0; m_hi = 0; m_lo = 0; m_pend = 0; done_at = 0;
        end else begin
            cyc++;
            if (m_run) begin
                if (cyc == done_at) begin
                    {m_hi, m_lo} = m_pend;
                    m_run = 0;
                end
            end else if (bus.Start) begin
                if (bus.MDOp <= 3'd3) begin
                    m_pend  = calc(bus.MDOp, bus.A, bus.B, {m_hi, m_lo});
                    done_at = cyc + (bus.MDOp >= 3'd2 ? 10 : 5);
                    m_run   = 1;
                end else if (bus.MDOp == 3'd4) m_hi = bus.A;
                else if (bus.MDOp == 3'd5) m_lo = bus.A;
            end
        end
    end

    always @(posedge clk) if (rst_n) assert (!(bus.Start && bus.Busy));

    always @(negedge clk) begin
        chk("busy", 32'(bus.Busy), 32'(m_run));
        chk("hi", bus.HI, m_hi);
        chk("lo", bus.LO, m_lo);
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.Busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", 32'(n >= 100), 32'd0);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.Start = 1'b1; bus.MDOp = op; bus.A = a; bus.B = b;
        @(posedge clk); #1;
        bus.Start = 1'b0;
    endtask

    task automatic busy_len(input string name, input int exp);
        int n = 0;
        while (bus.Busy && n < 50) begin
            n++;
            @(posedge clk); #1;
        end
        chk(name, n, exp);
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus.Start = 0; bus.MDOp = 0; bus.A = 0; bus.B = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy", 32'(bus.Busy), 32'd0);
        chk("rst_hi", bus.HI, 32'd0);
        chk("rst_lo", bus.LO, 32'd0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        issue(3'd0, 32'hFFFFFFFD, 32'd5);
        busy_len("mult_busy_len", 5);
        chk("mult_hi", bus.HI, 32'hFFFFFFFF);
        chk("mult_lo", bus.LO, 32'hFFFFFFF1);
        issue(3'd1, 32'hFFFFFFFF, 32'd2);
        busy_len("multu_busy_len", 5);
        chk("multu_hi", bus.HI, 32'h00000001);
        chk("multu_lo", bus.LO, 32'hFFFFFFFE);
        issue(3'd2, 32'hFFFFFFF9, 32'd2);
        busy_len("div_busy_len", 10);
        chk("div_lo", bus.LO, 32'hFFFFFFFD);
        chk("div_hi", bus.HI, 32'hFFFFFFFF);
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_idle();
        chk("divovf_lo", bus.LO, 32'h80000000);
        chk("divovf_hi", bus.HI, 32'h0);
        issue(3'd4, 32'h1234, 32'h0);
        chk("mthi_hi", bus.HI, 32'h1234);
        issue(3'd3, 32'hDEAD, 32'h0);
        busy_len("divu0_busy_len", 10);
        chk("divu0_hi", bus.HI, 32'h1234);
        chk("divu0_lo", bus.LO, 32'h80000000);
        issue(3'd5, 32'hCAFE, 32'h0);
        chk("mtlo_lo", bus.LO, 32'hCAFE);
        busy_len("mtlo_busy_len", 0);
        issue(3'd6, 32'h5555, 32'h7);
        chk("rsv_hi", bus.HI, 32'h1234);
        chk("rsv_lo", bus.LO, 32'hCAFE);
        issue(3'd0, 32'h7, 32'h9);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.Busy), 32'd0);
        chk("arst_hi", bus.HI, 32'h0);
        chk("arst_lo", bus.LO, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (8) begin @(posedge clk); #1; end
        chk("nolate_busy", 32'(bus.Busy), 32'd0);
        chk("nolate_hi", bus.HI, 32'h0);
        chk("nolate_lo", bus.LO, 32'h0);
        for (int i = 0; i < 300; i++) begin
            wait_idle();
            repeat ($urandom_range(0, 2)) begin
                bus.MDOp = 3'($urandom); bus.A = $urandom; bus.B = $urandom;
                @(posedge clk); #1;
            end
            issue(3'($urandom_range(0, 7)), rnd32(), rnd32());
            if (i % 100 == 60) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                #($urandom_range(1, 3)) rst_n = 1'b0;
                @(posedge clk); #1 rst_n = 1'b1;
            end
        end
        wait_idle();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
